// File: rtl/pipeexe_md.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipeexe_md : EXE stage ALU with iterative multiply/divide (HI/LO)      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module pipeexe_md #(
  parameter int WIDTH = 32,
  parameter int RBITS = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       ealuc,
  input  logic             ealuimm,
  input  logic             eshift,
  input  logic             ejal,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [WIDTH-1:0] eimm,
  input  logic [WIDTH-1:0] esa,
  input  logic [WIDTH-1:0] epc4,
  input  logic [RBITS-1:0] ern0,
  input  logic [2:0]       emd_op,
  output logic [WIDTH-1:0] ealu,
  output logic [RBITS-1:0] ern,
  output logic             estall,
  output logic             ebusy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi, r_lo, r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q, r_neg_r, r_dz;

  logic [WIDTH-1:0]   w_a, w_b, w_alu, w_ma, w_mb, w_quo, w_rem;
  logic [CW-1:0]      w_sh;
  logic               w_is_mul, w_is_div, w_signed, w_last;
  logic [WIDTH:0]     w_msum, w_dtrial, w_ddiff;
  logic [2*WIDTH-1:0] w_step, w_prod;

  always_comb begin
    w_a   = eshift ? esa : ea;
    w_b   = ealuimm ? eimm : eb;
    w_sh  = w_a[CW-1:0];
    w_alu = '0;
    casez (ealuc)
      4'b?000: w_alu = w_a + w_b;
      4'b?100: w_alu = w_a - w_b;
      4'b?001: w_alu = w_a & w_b;
      4'b?101: w_alu = w_a | w_b;
      4'b?010: w_alu = w_a ^ w_b;
      4'b?110: w_alu = w_b << (WIDTH / 2);
      4'b0011: w_alu = w_b << w_sh;
      4'b0111: w_alu = w_b >> w_sh;
      4'b1111: w_alu = $signed(w_b) >>> w_sh;
      default: w_alu = '0;
    endcase
  end

  assign w_is_mul = (emd_op == 3'd1) || (emd_op == 3'd2);
  assign w_is_div = (emd_op == 3'd3) || (emd_op == 3'd4);
  assign w_signed = (emd_op == 3'd1) || (emd_op == 3'd3);
  assign w_ma     = (w_signed && ea[WIDTH-1]) ? -ea : ea;
  assign w_mb     = (w_signed && eb[WIDTH-1]) ? -eb : eb;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_is_mul)      w_state_nx = S_MUL;
        else if (w_is_div) w_state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_dtrial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ddiff  = w_dtrial - {1'b0, r_opnd};
    if (r_state == S_MUL)
      w_step = {w_msum, r_acc[WIDTH-1:1]};
    else if (w_ddiff[WIDTH])
      w_step = {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    else
      w_step = {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  // With a zero divisor the remainder path reproduces the dividend itself.
  assign w_prod = r_neg_q ? -w_step : w_step;
  assign w_quo  = r_dz ? '1 : (r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0]);
  assign w_rem  = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (w_is_mul || w_is_div) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, (w_is_mul ? w_mb : w_ma)};
            r_opnd  <= w_is_mul ? w_ma : w_mb;
            r_neg_q <= w_signed && (ea[WIDTH-1] ^ eb[WIDTH-1]);
            r_neg_r <= w_signed && w_is_div && ea[WIDTH-1];
            r_dz    <= w_is_div && (eb == '0);
          end
        end
        default: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            if (r_state == S_MUL) begin
              {r_hi, r_lo} <= w_prod;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    if (ejal)                     ealu = epc4;
    else if (emd_op == 3'd5)      ealu = r_hi;
    else if (emd_op == 3'd6)      ealu = r_lo;
    else if (w_is_mul || w_is_div) ealu = '0;
    else                          ealu = w_alu;
  end

  assign ern    = ejal ? '1 : ern0;
  assign ebusy  = r_busy;
  assign estall = r_busy && (emd_op != 3'd0) && (emd_op != 3'd7);

endmodule
`default_nettype wire

// File: tb/tb_pipeexe_md.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipeexe_md : directed + random checks of pipeexe_md (WIDTH=32)      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_pipeexe_md;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetn;
  logic [3:0]   ealuc;
  logic         ealuimm, eshift, ejal;
  logic [W-1:0] ea, eb, eimm, esa, epc4;
  logic [4:0]   ern0;
  logic [2:0]   emd_op;
  logic [W-1:0] ealu;
  logic [4:0]   ern;
  logic         estall, ebusy;

  int n_cmp = 0;
  int n_err = 0;

  pipeexe_md #(.WIDTH(W), .RBITS(5)) dut (
    .clock(clock), .resetn(resetn), .ealuc(ealuc), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .ea(ea), .eb(eb), .eimm(eimm), .esa(esa),
    .epc4(epc4), .ern0(ern0), .emd_op(emd_op), .ealu(ealu), .ern(ern),
    .estall(estall), .ebusy(ebusy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ealuc = 4'd0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
    ea = '0; eb = '0; eimm = '0; esa = '0; epc4 = '0; ern0 = '0; emd_op = 3'd0;
  endtask

  function automatic logic [W-1:0] alu_model(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int unsigned s;
    s = a % 32;
    case (c)
      4'd0, 4'd8:   return a + b;
      4'd4, 4'd12:  return a - b;
      4'd1, 4'd9:   return a & b;
      4'd5, 4'd13:  return a | b;
      4'd2, 4'd10:  return a ^ b;
      4'd6, 4'd14:  return b * 32'h0001_0000;
      4'd3:         return b << s;
      4'd7:         return b >> s;
      4'd15:        return $signed(b) >>> s;
      default:      return '0;
    endcase
  endfunction

  // {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] res, qv, rv;
    if (op == 3'd1 || op == 3'd3) begin
      sa = $signed(a); sb = $signed(b);
    end else begin
      sa = {32'b0, a}; sb = {32'b0, b};
    end
    if (op == 3'd1 || op == 3'd2) begin
      res = sa * sb;
    end else if (b == '0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q = sa / sb; r = sa % sb; qv = q; rv = r;
      res = {rv[31:0], qv[31:0]};
    end
    return res;
  endfunction

  // Issue one md op in the current cycle, check 32 busy cycles and HI/LO afterwards.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    logic [63:0] exp;
    int nb;
    exp = md_model(op, a, b);
    idle_inputs();
    emd_op = op; ea = a; eb = b;
    #1;
    chk({tag, " accept estall"}, estall, 0);
    tick();
    idle_inputs();
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      if (ebusy !== 1'b1) break;
      nb++;
      tick();
    end
    chk({tag, " busy cycles"}, nb, 32);
    emd_op = 3'd6; #1;
    chk({tag, " LO"}, ealu, exp[31:0]);
    chk({tag, " mflo estall"}, estall, 0);
    emd_op = 3'd5; #1;
    chk({tag, " HI"}, ealu, exp[63:32]);
    idle_inputs();
  endtask

  initial begin
    logic [W-1:0] a, b, exp32;
    logic [2:0]   op;
    int           n;

    // Reset state
    idle_inputs();
    resetn = 1'b0;
    #3;
    chk("reset ebusy", ebusy, 0);
    emd_op = 3'd5; #1;
    chk("reset estall", estall, 0);
    chk("reset HI", ealu, 0);
    emd_op = 3'd6; #1;
    chk("reset LO", ealu, 0);
    idle_inputs();
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Random ALU ops (non-md instructions never stall)
    for (int i = 0; i < 16; i++) begin
      idle_inputs();
      ealuc = 4'($urandom_range(0, 15));
      eshift = 1'($urandom); ealuimm = 1'($urandom);
      ea = $urandom; eb = $urandom; eimm = $urandom; esa = $urandom_range(0, 40);
      ern0 = 5'($urandom);
      emd_op = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
      #1;
      exp32 = alu_model(ealuc, eshift ? esa : ea, ealuimm ? eimm : eb);
      chk($sformatf("alu c=%0d", ealuc), ealu, exp32);
      chk("alu ern", ern, ern0);
      chk("alu estall", estall, 0);
      tick();
    end

    // Directed md cases
    run_md("mult -3*7", 3'd1, 32'hFFFF_FFFD, 32'd7);
    run_md("divu 100/7", 3'd4, 32'd100, 32'd7);
    run_md("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2);
    run_md("divu 5/0", 3'd4, 32'd5, 32'd0);
    run_md("div -5/0", 3'd3, 32'hFFFF_FFFB, 32'd0);
    run_md("div minneg/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();

    // mult 3*4, mfhi presented in cycle 5: stall 5..32, ealu=0 in 33
    idle_inputs(); emd_op = 3'd1; ea = 32'd3; eb = 32'd4;
    tick();
    idle_inputs();
    for (int c = 1; c < 5; c++) tick();
    emd_op = 3'd5;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (estall !== 1'b1) break;
      n++;
      tick();
    end
    chk("mfhi stall cycles", n, 28);
    chk("mfhi after stall", ealu, 0);
    chk("busy after stall", ebusy, 0);
    idle_inputs(); tick();

    // jal while busy
    idle_inputs(); emd_op = 3'd2; ea = 32'd9; eb = 32'd9;
    tick();
    idle_inputs(); ejal = 1'b1; epc4 = 32'h0040_0008; ern0 = 5'd0; ealuc = 4'd4;
    #1;
    chk("jal ealu", ealu, 32'h0040_0008);
    chk("jal ern", ern, 5'd31);
    chk("jal estall", estall, 0);
    chk("jal ebusy", ebusy, 1);
    idle_inputs();
    for (int c = 0; c < 40 && ebusy === 1'b1; c++) tick();

    // multu followed by multu presented in cycle 1
    idle_inputs(); emd_op = 3'd2; ea = 32'hFFFF_FFFF; eb = 32'd2;
    tick();
    a = $urandom; b = $urandom;
    ea = a; eb = b;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (estall !== 1'b1) break;
      n++;
      tick();
    end
    chk("2nd multu stall cycles", n, 32);
    emd_op = 3'd6; #1;
    chk("1st multu LO", ealu, 32'hFFFF_FFFE);
    emd_op = 3'd2; #1;
    tick();
    idle_inputs();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (ebusy !== 1'b1) break;
      n++;
      tick();
    end
    chk("2nd multu busy cycles", n, 32);
    exp32 = md_model(3'd2, a, b) >> 32;
    emd_op = 3'd5; #1;
    chk("2nd multu HI", ealu, exp32);
    idle_inputs(); tick();

    // Reset in cycle 10 of a mult aborts it
    idle_inputs(); emd_op = 3'd1; ea = 32'd123456; eb = 32'hFFFF_0001;
    tick();
    idle_inputs();
    for (int c = 1; c < 10; c++) tick();
    resetn = 1'b0;
    #1;
    chk("abort ebusy", ebusy, 0);
    emd_op = 3'd6; #1;
    chk("abort LO", ealu, 0);
    chk("abort estall", estall, 0);
    emd_op = 3'd5; #1;
    chk("abort HI", ealu, 0);
    idle_inputs();
    tick(); tick();
    resetn = 1'b1;
    emd_op = 3'd6; #1;
    chk("post-reset mflo", ealu, 0);
    // first edge after release accepts an md op
    run_md("post-reset mult", 3'd1, 32'h0001_0003, 32'hFFFF_FFF0);
    tick();

    // Random md ops
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      run_md($sformatf("rand op%0d %h,%h", op, a, b), op, a, b);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeexe_md.md
PIPEEXE_MD -- requirements
Module: pipeexe_md

Interface
REQ-001 Parameter WIDTH, default 32: datapath width of all operands and results.
REQ-002 Parameter RBITS, default 5: register-number width.
REQ-003 clock  in  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 ealuc  in  4  ALU operation, using the codebase's existing ealuc encoding, evaluated at WIDTH bits.
REQ-006 ealuimm  in  1  selects eimm instead of eb as ALU operand B.
REQ-007 eshift  in  1  selects esa instead of ea as ALU operand A.
REQ-008 ejal  in  1  link: result is epc4, destination is register all-ones.
REQ-009 ea, eb, eimm, esa, epc4  in  WIDTH each  operands and link address.
REQ-010 ern0  in  RBITS  decoded destination register.
REQ-011 emd_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 reserved (treated as 0).
REQ-012 ealu  out  WIDTH  stage result.
REQ-013 ern  out  RBITS  final destination register.
REQ-014 estall  out  1  upstream holds all inputs stable and inserts a bubble downstream while high.
REQ-015 ebusy  out  1  multiply/divide iteration in progress.

Function
REQ-016 ALU path is combinational: A = eshift ? esa : ea; B = ealuimm ? eimm : eb.
REQ-017 ealu priority: ejal -> epc4; else emd_op 5/6 -> HI/LO; else emd_op 1-4 -> 0; else ALU result.
REQ-018 ern = all-ones when ejal=1, else ern0; combinational.
REQ-019 FSM states: IDLE, MUL, DIV.
REQ-020 IDLE -> MUL on emd_op 1/2, IDLE -> DIV on emd_op 3/4; operands latched from ea/eb at that edge (cycle 0).
REQ-021 MUL/DIV run exactly WIDTH iterations, one bit per cycle, counted by a wrap-free counter 0..WIDTH-1.
REQ-022 ebusy is registered and high in cycles 1..WIDTH.
REQ-023 HI/LO are written at the end of cycle WIDTH; the FSM returns to IDLE at that same edge.
REQ-024 Multiply uses shift-add on magnitudes; signed mult negates the 2*WIDTH product when operand signs differ; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-025 Divide uses restoring division on magnitudes; LO = quotient, HI = remainder.
REQ-026 Signed div: the quotient is negated if operand signs differ; the remainder takes the dividend's sign.
REQ-027 Divisor zero: HI = dividend, LO = all-ones; the full WIDTH-cycle latency still applies.
REQ-028 estall = ebusy AND emd_op in 1..6; a stalled op is accepted in the first cycle with ebusy=0.
REQ-029 estall does not depend on ejal or ealuc; non-md instructions never stall.
REQ-030 mfhi/mflo when not busy return HI/LO in the same cycle, with no added latency.

Reset
REQ-031 resetn low immediately forces state IDLE, counter 0, HI=0, LO=0, ebusy=0, estall=0.
REQ-032 Reset during MUL/DIV aborts the operation; no partial result reaches HI/LO.
REQ-033 The first edge after resetn rises may accept an md op.

Verification (WIDTH=32)
REQ-034 mult ea=0xFFFFFFFD, eb=7 -> ebusy cycles 1..32; mflo in cycle 33 gives ealu=0xFFFFFFEB; mfhi gives 0xFFFFFFFF.
REQ-035 divu 100/7 -> LO=14, HI=2; div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 5/0 -> HI=5, LO=0xFFFFFFFF.
REQ-036 mult 3*4 in cycle 0, mfhi presented in cycle 5 -> estall high cycles 5..32 (28 cycles); ealu=0 in cycle 33.
REQ-037 multu then multu presented in cycle 1 -> second op stalled until cycle 33, accepted there, ebusy high cycles 34..65.
REQ-038 ejal=1, epc4=0x00400008, ern0=0 -> ealu=0x00400008, ern=31 same cycle, estall=0 even while busy.
REQ-039 Reset asserted in cycle 10 of a mult -> ebusy=0, HI=LO=0 immediately; mflo after release returns 0.
